placar_parametrizado: RTL and testbench

//   Parametrised scoreboard core for N_TIMES teams. Point buttons add or subtract 1..N_BOTOES points
//   on the team picked by chaveTime, with saturation. A sequential comparator then finds the leader
//   or a tie, and the buzzer pulses on every accepted score change. Display/7-seg decode sits downstream.

---
 rtl/placar_parametrizado.sv | 230 +++++++++++++++++++++++
 tb/tb_placar_parametrizado.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/placar_parametrizado.sv
// Parametrised scoreboard core: button presses add or subtract points with saturation,
// a sequential scan finds the leader/tie, and the buzzer pulses on every accepted change.
module placar_parametrizado #(
    parameter int N_TIMES     = 2,
    parameter int W_PONTOS    = 7,
    parameter int MAX_PONTOS  = 127,
    parameter int N_BOTOES    = 3,
    parameter int BUZZ_CICLOS = 4,
    localparam int W_SEL      = ($clog2(N_TIMES) > 1) ? $clog2(N_TIMES) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_BOTOES-1:0]          cBotoes,
    input  logic                         chaveNP,
    input  logic [W_SEL-1:0]             chaveTime,
    output logic [N_TIMES*W_PONTOS-1:0]  placar,
    output logic [W_SEL-1:0]             lider,
    output logic                         empate,
    output logic [N_TIMES-1:0]           led,
    output logic                         buzzer,
    output logic                         ocupado,
    output logic                         erro
);

    localparam int W_VAL = $clog2(N_BOTOES + 1);
    localparam int W_CNT = (BUZZ_CICLOS > 1) ? $clog2(BUZZ_CICLOS) : 1;
    localparam int W_EQ  = $clog2(N_TIMES + 1);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ATUALIZA = 2'd1,
        COMPARA  = 2'd2
    } estado_t;

    estado_t                state_r;
    estado_t                state_nx_s;

    logic [N_BOTOES-1:0]    prev_r;
    logic [N_BOTOES-1:0]    rise_s;
    logic                   one_hot_s;
    logic                   sel_ok_s;
    logic                   accept_s;
    logic                   reject_s;
    logic [W_VAL-1:0]       btn_val_s;

    logic [W_SEL-1:0]       team_r;
    logic [W_VAL-1:0]       val_r;
    logic                   np_r;

    logic [W_PONTOS-1:0]    score_r [N_TIMES];
    logic [W_PONTOS-1:0]    old_s;
    logic [W_PONTOS-1:0]    new_s;
    logic [W_PONTOS:0]      ext_s;
    logic                   changed_s;

    logic [W_SEL-1:0]       idx_r;
    logic [W_PONTOS-1:0]    max_r;
    logic [W_EQ-1:0]        cnt_eq_r;
    logic [W_SEL-1:0]       lid_r;
    logic [N_TIMES-1:0]     mask_r;
    logic [W_PONTOS-1:0]    scan_s;
    logic [W_PONTOS-1:0]    nx_max_s;
    logic [W_EQ-1:0]        nx_cnt_s;
    logic [W_SEL-1:0]       nx_lid_s;
    logic [N_TIMES-1:0]     nx_mask_s;
    logic                   last_s;

    logic [W_SEL-1:0]       lider_r;
    logic                   empate_r;
    logic [N_TIMES-1:0]     led_r;
    logic                   buzzer_r;
    logic [W_CNT-1:0]       buz_cnt_r;
    logic                   ocupado_r;
    logic                   erro_r;
    logic                   err_pend_r;

    // Press decode: rising edges, single-button check and point value of the pressed button
    always_comb begin
        rise_s    = cBotoes & ~prev_r;
        btn_val_s = {W_VAL{1'b0}};
        for (int i = 0; i < N_BOTOES; i++) begin
            btn_val_s = rise_s[i] ? W_VAL'(i + 1) : btn_val_s;
        end
        one_hot_s = (rise_s != {N_BOTOES{1'b0}}) &&
                    ((rise_s & (rise_s - N_BOTOES'(1))) == {N_BOTOES{1'b0}});
        sel_ok_s  = ({1'b0, chaveTime} < (W_SEL + 1)'(N_TIMES));
        accept_s  = (state_r == OCIOSO) && one_hot_s && sel_ok_s;
        reject_s  = (state_r == OCIOSO) && (rise_s != {N_BOTOES{1'b0}}) && !(one_hot_s && sel_ok_s);
    end

    // Saturating add/subtract, computed one bit wider so the clamp sees the overflow
    always_comb begin
        old_s = score_r[team_r];
        if (np_r) begin
            ext_s = {1'b0, old_s} - (W_PONTOS + 1)'(val_r);
            new_s = ext_s[W_PONTOS] ? {W_PONTOS{1'b0}} : ext_s[W_PONTOS-1:0];
        end else begin
            ext_s = {1'b0, old_s} + (W_PONTOS + 1)'(val_r);
            new_s = (ext_s > (W_PONTOS + 1)'(MAX_PONTOS)) ? W_PONTOS'(MAX_PONTOS)
                                                          : ext_s[W_PONTOS-1:0];
        end
        changed_s = (state_r == ATUALIZA) && (new_s != old_s);
    end

    // Scan step: fold one team into the running maximum, tie count and leader mask
    always_comb begin
        scan_s    = score_r[idx_r];
        last_s    = (idx_r == W_SEL'(N_TIMES - 1));
        nx_max_s  = max_r;
        nx_cnt_s  = cnt_eq_r;
        nx_lid_s  = lid_r;
        nx_mask_s = mask_r;
        if ((idx_r == {W_SEL{1'b0}}) || (scan_s > max_r)) begin
            nx_max_s  = scan_s;
            nx_cnt_s  = W_EQ'(1);
            nx_lid_s  = idx_r;
            nx_mask_s = N_TIMES'(1) << idx_r;
        end else if (scan_s == max_r) begin
            nx_cnt_s  = cnt_eq_r + W_EQ'(1);
            nx_mask_s = mask_r | (N_TIMES'(1) << idx_r);
        end else begin
            nx_max_s  = max_r;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            OCIOSO:   state_nx_s = accept_s ? ATUALIZA : OCIOSO;
            ATUALIZA: state_nx_s = COMPARA;
            COMPARA:  state_nx_s = last_s ? OCIOSO : COMPARA;
            default:  state_nx_s = OCIOSO;
        endcase
    end

    // State register and edge-detect history (history loads even during reset)
    always_ff @(posedge clock) begin
        prev_r <= cBotoes;
        if (reset) begin
            state_r   <= OCIOSO;
            ocupado_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            ocupado_r <= (state_nx_s != OCIOSO);
        end
    end

    // Press latch, score update and error pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            team_r     <= {W_SEL{1'b0}};
            val_r      <= {W_VAL{1'b0}};
            np_r       <= 1'b0;
            err_pend_r <= 1'b0;
            erro_r     <= 1'b0;
            for (int t = 0; t < N_TIMES; t++) begin
                score_r[t] <= {W_PONTOS{1'b0}};
            end
        end else begin
            if (accept_s) begin
                team_r <= chaveTime;
                val_r  <= btn_val_s;
                np_r   <= chaveNP;
            end
            if (state_r == ATUALIZA) begin
                score_r[team_r] <= new_s;
            end
            err_pend_r <= reject_s;
            erro_r     <= err_pend_r;
        end
    end

    // Buzzer: a change reloads the full pulse length, otherwise count down
    always_ff @(posedge clock) begin
        if (reset) begin
            buzzer_r  <= 1'b0;
            buz_cnt_r <= {W_CNT{1'b0}};
        end else if (changed_s) begin
            buzzer_r  <= 1'b1;
            buz_cnt_r <= W_CNT'(BUZZ_CICLOS - 1);
        end else if (buz_cnt_r != {W_CNT{1'b0}}) begin
            buzzer_r  <= 1'b1;
            buz_cnt_r <= buz_cnt_r - W_CNT'(1);
        end else begin
            buzzer_r  <= 1'b0;
        end
    end

    // Sequential comparator; leader outputs change only at the final scan step
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_r    <= {W_SEL{1'b0}};
            max_r    <= {W_PONTOS{1'b0}};
            cnt_eq_r <= {W_EQ{1'b0}};
            lid_r    <= {W_SEL{1'b0}};
            mask_r   <= {N_TIMES{1'b0}};
            lider_r  <= {W_SEL{1'b0}};
            empate_r <= 1'b1;
            led_r    <= {N_TIMES{1'b1}};
        end else if (state_r == ATUALIZA) begin
            idx_r <= {W_SEL{1'b0}};
        end else if (state_r == COMPARA) begin
            idx_r    <= idx_r + W_SEL'(1);
            max_r    <= nx_max_s;
            cnt_eq_r <= nx_cnt_s;
            lid_r    <= nx_lid_s;
            mask_r   <= nx_mask_s;
            if (last_s) begin
                lider_r  <= nx_lid_s;
                empate_r <= (nx_cnt_s >= W_EQ'(2));
                led_r    <= nx_mask_s;
            end
        end else begin
            idx_r <= idx_r;
        end
    end

    for (genvar t = 0; t < N_TIMES; t++) begin : g_placar
        assign placar[t*W_PONTOS +: W_PONTOS] = score_r[t];
    end

    assign lider   = lider_r;
    assign empate  = empate_r;
    assign led     = led_r;
    assign buzzer  = buzzer_r;
    assign ocupado = ocupado_r;
    assign erro    = erro_r;

endmodule

// File: tb/tb_placar_parametrizado.sv
// Randomised and directed bench for placar_parametrizado (three teams, so an out-of-range
// team select is reachable), checked every cycle against a cycle-counting score model.
module tb_placar_parametrizado;

    localparam int NT = 3;
    localparam int WP = 7;
    localparam int MAXP = 127;
    localparam int NB = 3;
    localparam int BZ = 4;
    localparam int WS = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic [NB-1:0]     cBotoes;
    logic              chaveNP;
    logic [WS-1:0]     chaveTime;
    logic [NT*WP-1:0]  placar;
    logic [WS-1:0]     lider;
    logic              empate;
    logic [NT-1:0]     led;
    logic              buzzer;
    logic              ocupado;
    logic              erro;

    placar_parametrizado #(
        .N_TIMES(NT), .W_PONTOS(WP), .MAX_PONTOS(MAXP), .N_BOTOES(NB), .BUZZ_CICLOS(BZ)
    ) dut (
        .clock(clock), .reset(reset), .cBotoes(cBotoes), .chaveNP(chaveNP),
        .chaveTime(chaveTime), .placar(placar), .lider(lider), .empate(empate),
        .led(led), .buzzer(buzzer), .ocupado(ocupado), .erro(erro)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // reference model state
    int            sc [NT];
    int            m_lider;
    bit            m_empate;
    logic [NT-1:0] m_led;
    int            m_buzz_left;
    int            m_rem;
    bit            m_err_pend;
    bit            m_erro;
    logic [NB-1:0] m_prev;
    int            m_team;
    int            m_val;
    bit            m_np;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_commit();
        int mx;
        int cnt;
        mx = -1;
        cnt = 0;
        for (int t = 0; t < NT; t++) begin
            if (sc[t] > mx) begin
                mx = sc[t];
                m_lider = t;
            end
        end
        m_led = '0;
        for (int t = 0; t < NT; t++) begin
            if (sc[t] == mx) begin
                cnt++;
                m_led[t] = 1'b1;
            end
        end
        m_empate = (cnt >= 2);
    endtask

    task automatic model_step();
        logic [NB-1:0] rise;
        int old;
        int nw;
        if (reset) begin
            for (int t = 0; t < NT; t++) sc[t] = 0;
            m_lider = 0;
            m_empate = 1'b1;
            m_led = '1;
            m_buzz_left = 0;
            m_rem = 0;
            m_err_pend = 1'b0;
            m_erro = 1'b0;
        end else begin
            rise = cBotoes & ~m_prev;
            m_erro = m_err_pend;
            m_err_pend = 1'b0;
            if (m_buzz_left > 0) m_buzz_left--;
            if (m_rem > 0) begin
                if (m_rem == NT + 1) begin
                    old = sc[m_team];
                    if (m_np) nw = (old - m_val < 0) ? 0 : old - m_val;
                    else      nw = (old + m_val > MAXP) ? MAXP : old + m_val;
                    sc[m_team] = nw;
                    if (nw != old) m_buzz_left = BZ;
                end
                m_rem--;
                if (m_rem == 0) model_commit();
            end else if (rise != '0) begin
                if ($countones(rise) == 1 && int'(chaveTime) < NT) begin
                    m_team = int'(chaveTime);
                    for (int i = 0; i < NB; i++) if (rise[i]) m_val = i + 1;
                    m_np = chaveNP;
                    m_rem = NT + 1;
                end else begin
                    m_err_pend = 1'b1;
                end
            end
        end
        m_prev = cBotoes;
    endtask

    task automatic compare_all();
        for (int t = 0; t < NT; t++) begin
            check_val($sformatf("placar%0d", t), 32'(placar[t*WP +: WP]), sc[t]);
        end
        check_val("lider", 32'(lider), m_lider);
        check_val("empate", 32'(empate), 32'(m_empate));
        check_val("led", 32'(led), 32'(m_led));
        check_val("buzzer", 32'(buzzer), (m_buzz_left > 0) ? 1 : 0);
        check_val("ocupado", 32'(ocupado), (m_rem > 0) ? 1 : 0);
        check_val("erro", 32'(erro), 32'(m_erro));
    endtask

    // drive at negedge, model at posedge, compare at the next negedge
    task automatic cycle(input logic [NB-1:0] cb, input logic np, input logic [WS-1:0] ts,
                         input logic rst);
        cBotoes = cb;
        chaveNP = np;
        chaveTime = ts;
        reset = rst;
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(3'b000, 1'($urandom), 2'($urandom), 1'b0);
    endtask

    task automatic press(input int team, input logic [NB-1:0] btn, input logic np);
        cycle(btn, np, 2'(team), 1'b0);
        idle(NT + 2);
    endtask

    initial begin
        logic [NB-1:0] cb;
        int r;
        @(negedge clock);
        cycle(3'b000, 1'b0, 2'd0, 1'b1);
        cycle(3'b000, 1'b0, 2'd0, 1'b1);
        check_val("rst_empate", 32'(empate), 1);
        check_val("rst_led", 32'(led), 32'h7);
        idle(2);

        // first press: +3 on team 0
        cycle(3'b100, 1'b0, 2'd0, 1'b0);
        cycle(3'b100, 1'b1, 2'd2, 1'b0);
        check_val("p1_score", 32'(placar[0 +: WP]), 3);
        check_val("p1_buzz", 32'(buzzer), 1);
        cycle(3'b000, 1'b1, 2'd1, 1'b0);
        cycle(3'b000, 1'b0, 2'd1, 1'b0);
        check_val("p1_old_empate", 32'(empate), 1);
        cycle(3'b000, 1'b0, 2'd1, 1'b0);
        check_val("p1_empate", 32'(empate), 0);
        check_val("p1_led", 32'(led), 32'h1);
        idle(3);

        // team 1 up to 126, then saturate
        for (int i = 0; i < 42; i++) press(1, 3'b100, 1'b0);
        check_val("t1_126", 32'(placar[WP +: WP]), 126);
        press(1, 3'b100, 1'b0);
        check_val("t1_sat", 32'(placar[WP +: WP]), 127);
        cycle(3'b001, 1'b0, 2'd1, 1'b0);
        cycle(3'b000, 1'b0, 2'd1, 1'b0);
        check_val("t1_nobuzz", 32'(buzzer), 0);
        idle(NT + 2);

        // team 0: 3 -> 2 -> 0 (floor) -> 0
        press(0, 3'b001, 1'b1);
        press(0, 3'b100, 1'b1);
        check_val("t0_floor", 32'(placar[0 +: WP]), 0);
        cycle(3'b001, 1'b1, 2'd0, 1'b0);
        cycle(3'b000, 1'b1, 2'd0, 1'b0);
        check_val("t0_nobuzz", 32'(buzzer), 0);
        idle(NT + 2);

        // tie at 5 between teams 0 and 1
        cycle(3'b000, 1'b0, 2'd0, 1'b1);
        press(0, 3'b100, 1'b0);
        press(0, 3'b010, 1'b0);
        press(1, 3'b010, 1'b0);
        press(1, 3'b100, 1'b0);
        check_val("tie_empate", 32'(empate), 1);
        check_val("tie_led", 32'(led), 32'h3);
        check_val("tie_lider", 32'(lider), 0);

        // two buttons at once, then out-of-range team
        cycle(3'b011, 1'b0, 2'd0, 1'b0);
        cycle(3'b000, 1'b0, 2'd0, 1'b0);
        check_val("two_btn_erro", 32'(erro), 1);
        cycle(3'b001, 1'b0, 2'd3, 1'b0);
        cycle(3'b000, 1'b0, 2'd0, 1'b0);
        check_val("bad_team_erro", 32'(erro), 1);
        check_val("bad_team_score", 32'(placar[0 +: WP]), 5);

        // button held through reset is not a press
        cycle(3'b001, 1'b0, 2'd2, 1'b1);
        cycle(3'b001, 1'b0, 2'd2, 1'b0);
        cycle(3'b001, 1'b0, 2'd2, 1'b0);
        check_val("held_rst_busy", 32'(ocupado), 0);
        idle(2);

        // press during the compare scan is ignored
        cycle(3'b010, 1'b0, 2'd2, 1'b0);
        cycle(3'b000, 1'b0, 2'd2, 1'b0);
        cycle(3'b100, 1'b0, 2'd2, 1'b0);
        idle(NT + 2);
        check_val("busy_ignored", 32'(placar[2*WP +: WP]), 2);

        // reset during ATUALIZA
        cycle(3'b100, 1'b0, 2'd1, 1'b0);
        cycle(3'b000, 1'b0, 2'd1, 1'b1);
        check_val("rst_mid_buzz", 32'(buzzer), 0);
        check_val("rst_mid_score", 32'(placar[WP +: WP]), 0);
        idle(3);

        // random phase
        cb = '0;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      cb = '0;
            else if (r < 8) cb = NB'(1) << $urandom_range(0, NB - 1);
            else            cb = NB'($urandom);
            cycle(cb, 1'($urandom), 2'($urandom_range(0, 3)), ($urandom_range(0, 149) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
